// File: rtl/decode_exec_stage_pkg.sv
// Shared definitions for the decode/execute stage.
// Contents: opcode and funct encodings, instruction field positions,
// the ALU operation type and the funct -> ALU operation mapping.
package decode_exec_stage_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ALU_R = 3'b001,
    OP_LW    = 3'b010,
    OP_SW    = 3'b011,
    OP_ALU_I = 3'b100
  } opcode_e;

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_SUB = 3'b001,
    FN_AND = 3'b010,
    FN_OR  = 3'b011,
    FN_XOR = 3'b100,
    FN_SLL = 3'b101,
    FN_SRL = 3'b110,
    FN_SLT = 3'b111
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SLT
  } alu_op_e;

  // Least-significant bit of each instruction field.
  localparam int OP_LSB    = 29;
  localparam int RD_LSB    = 24;
  localparam int RS1_LSB   = 19;
  localparam int RS2_LSB   = 14;
  localparam int FUNCT_LSB = 11;
  localparam int REG_IDX_W = 5;
  // ALU-I uses only the low 11 bits as its immediate; the funct field sits above.
  localparam int ALU_IMM_W = 11;

  function automatic alu_op_e funct_to_alu_op(input funct_e fn);
    alu_op_e op;
    case (fn)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_XOR:  op = ALU_XOR;
      FN_SLL:  op = ALU_SLL;
      FN_SRL:  op = ALU_SRL;
      default: op = ALU_SLT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_exec_stage_alu.sv
// exec_alu: purely combinational XLEN-wide ALU.
// Ports: a, b operands; op selects the operation; y result.
// Shifts use the low $clog2(XLEN) bits of b; slt is a signed compare.
module exec_alu
  import decode_exec_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << shamt;
      ALU_SRL: y = a >> shamt;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/decode_exec_stage.sv
// decode_exec_stage: decodes one instruction per cycle, reads the register
// file (with writeback bypass), executes on exec_alu and presents a one-deep
// output bundle under a valid/ready handshake.
// Ports: clk, reset (async, active-high); in_valid/in_ready/instruction input
// handshake; out_valid/out_ready plus result, reg_write_enable,
// mem_read_enable, mem_write_enable, register, mem_address, store_data,
// illegal output bundle; wb_en/wb_reg/wb_data load writeback.
// A pending bit per register tracks outstanding loads; readers and writers of
// a pending register stall until its writeback arrives.
module decode_exec_stage
  import decode_exec_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int IMMW = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            reg_write_enable,
  output logic            mem_read_enable,
  output logic            mem_write_enable,
  output logic [4:0]      register,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] store_data,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_reg,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [5:0] NREG_L = 6'(NREG);

  // State
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d, addr_q, addr_d, sdata_q, sdata_d;
  logic            rwe_q, rwe_d, mre_q, mre_d, mwe_q, mwe_d, illegal_q, illegal_d;
  logic [4:0]      reg_q, reg_d;

  // Decode
  opcode_e                op;
  funct_e                 funct;
  logic [REG_IDX_W-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0]        imm_mem, imm_alu;
  logic [XLEN-1:0]        rs1_val, rs2_val, rd_val;
  logic [XLEN-1:0]        alu_a, alu_b, alu_y;
  alu_op_e                alu_op;
  logic                   dec_illegal, dec_rwe, dec_mre, dec_mwe, stall, accept;
  logic [4:0]             dec_reg;
  logic [XLEN-1:0]        dec_result, dec_addr, dec_sdata;

  assign op      = opcode_e'(instruction[OP_LSB +: 3]);
  assign funct   = funct_e'(instruction[FUNCT_LSB +: 3]);
  assign rd_idx  = instruction[RD_LSB +: REG_IDX_W];
  assign rs1_idx = instruction[RS1_LSB +: REG_IDX_W];
  assign rs2_idx = instruction[RS2_LSB +: REG_IDX_W];
  assign imm_mem = {{(XLEN-IMMW){instruction[IMMW-1]}}, instruction[IMMW-1:0]};
  assign imm_alu = {{(XLEN-ALU_IMM_W){instruction[ALU_IMM_W-1]}}, instruction[ALU_IMM_W-1:0]};

  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < NREG_L;
  endfunction

  // Register read with same-cycle writeback bypass; r0 is hard-wired to zero.
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    for (int i = 1; i < NREG; i++) begin
      if (idx == 5'(i)) v = rf_q[i];
    end
    if (wb_en && wb_reg == idx) v = wb_data;
    if (idx == 5'd0) v = '0;
    return v;
  endfunction

  // A register is busy if a load is outstanding and this cycle's writeback
  // does not retire it.
  function automatic logic busy(input logic [4:0] idx);
    logic p;
    p = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (idx == 5'(i)) p = pending_q[i];
    end
    return p && !(wb_en && wb_reg == idx);
  endfunction

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path infers a latch.
    rs1_val = read_reg(rs1_idx);
    rs2_val = read_reg(rs2_idx);
    rd_val  = read_reg(rd_idx);
    alu_a   = rs1_val;
    alu_b   = rs2_val;
    alu_op  = funct_to_alu_op(funct);
    case (op)
      OP_ALU_I:     alu_b = imm_alu;
      OP_LW, OP_SW: begin
        alu_b  = imm_mem;
        alu_op = ALU_ADD;
      end
      default: ;
    endcase
  end

  exec_alu #(.XLEN(XLEN)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  always_comb begin
    dec_illegal = 1'b0;
    dec_rwe     = 1'b0;
    dec_mre     = 1'b0;
    dec_mwe     = 1'b0;
    dec_reg     = '0;
    dec_result  = '0;
    dec_addr    = '0;
    dec_sdata   = '0;
    stall       = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ALU_R, OP_ALU_I: begin
        if (in_range(rd_idx) && in_range(rs1_idx) && (op == OP_ALU_I || in_range(rs2_idx))) begin
          dec_rwe    = 1'b1;
          dec_reg    = rd_idx;
          dec_result = alu_y;
          stall      = busy(rs1_idx) || busy(rd_idx) || (op == OP_ALU_R && busy(rs2_idx));
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_LW, OP_SW: begin
        // For SW the rd field names the store-data source register.
        if (in_range(rd_idx) && in_range(rs1_idx)) begin
          dec_result = alu_y;
          dec_addr   = alu_y;
          stall      = busy(rs1_idx) || busy(rd_idx);
          if (op == OP_LW) begin
            dec_mre = 1'b1;
            dec_reg = rd_idx;
          end else begin
            dec_mwe   = 1'b1;
            dec_sdata = rd_val;
          end
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign in_ready = !stall && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    rf_d        = rf_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    rwe_d       = rwe_q;
    mre_d       = mre_q;
    mwe_d       = mwe_q;
    illegal_d   = illegal_q;
    reg_d       = reg_q;

    if (wb_en) begin
      for (int i = 1; i < NREG; i++) begin
        if (wb_reg == 5'(i)) begin
          rf_d[i]      = wb_data;
          pending_d[i] = 1'b0;
        end
      end
    end

    if (accept) begin
      // Applied after the writeback: the accepted instruction is younger, so
      // its ALU write and its load's pending set both take precedence.
      for (int i = 1; i < NREG; i++) begin
        if (rd_idx == 5'(i)) begin
          if (dec_rwe) rf_d[i] = dec_result;
          if (dec_mre) pending_d[i] = 1'b1;
        end
      end
      out_valid_d = 1'b1;
      result_d    = dec_result;
      addr_d      = dec_addr;
      sdata_d     = dec_sdata;
      rwe_d       = dec_rwe;
      mre_d       = dec_mre;
      mwe_d       = dec_mwe;
      illegal_d   = dec_illegal;
      reg_d       = dec_reg;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      result_d    = '0;
      addr_d      = '0;
      sdata_d     = '0;
      rwe_d       = 1'b0;
      mre_d       = 1'b0;
      mwe_d       = 1'b0;
      illegal_d   = 1'b0;
      reg_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is architecturally zero after reset, so the
      // array is reset here rather than left to power-up contents.
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      rwe_q       <= 1'b0;
      mre_q       <= 1'b0;
      mwe_q       <= 1'b0;
      illegal_q   <= 1'b0;
      reg_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rf_q        <= rf_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      rwe_q       <= rwe_d;
      mre_q       <= mre_d;
      mwe_q       <= mwe_d;
      illegal_q   <= illegal_d;
      reg_q       <= reg_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign result           = result_q;
  assign reg_write_enable = rwe_q;
  assign mem_read_enable  = mre_q;
  assign mem_write_enable = mwe_q;
  assign register         = reg_q;
  assign mem_address      = addr_q;
  assign store_data       = sdata_q;
  assign illegal          = illegal_q;

endmodule

// File: tb/tb_decode_exec_stage.sv
module tb_decode_exec_stage;

  localparam int XLEN   = 32;
  localparam int NREG   = 16;
  localparam int IMMW   = 14;
  localparam int BUDGET = 60;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] result, mem_address, store_data, wb_data;
  logic            reg_write_enable, mem_read_enable, mem_write_enable, illegal, wb_en;
  logic [4:0]      register, wb_reg;

  decode_exec_stage #(.XLEN(XLEN), .NREG(NREG), .IMMW(IMMW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .reg_write_enable(reg_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .register(register), .mem_address(mem_address), .store_data(store_data),
    .illegal(illegal), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result, addr, sdata;
    logic        rwe, mre, mwe, ill;
    logic [4:0]  rg;
  } bundle_t;

  int          n_checks = 0, n_errors = 0;
  bundle_t     exp_q[$];
  logic [31:0] m_regs [32];
  logic        m_pending [32];
  logic        m_out_valid;
  logic [31:0] last_result;
  logic        rand_ready = 1'b0, rand_wb = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_en && wb_reg == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic mbusy(input logic [4:0] idx);
    return m_pending[idx] && !(wb_en && wb_reg == idx);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] fn, input logic [31:0] a, b);
    case (fn)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin : model
    logic [31:0] ins, a, opnd, ea;
    logic [2:0]  op, fn;
    logic [4:0]  rd, rs1, rs2;
    logic        stall, exp_ready, acc, wr, ld;
    bundle_t     b;
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pending[i] = 1'b0;
      end
      m_out_valid = 1'b0;
    end else begin
      ins = instruction;
      op = ins[31:29]; rd = ins[28:24]; rs1 = ins[23:19]; rs2 = ins[18:14]; fn = ins[13:11];
      b = '{result: 0, addr: 0, sdata: 0, rwe: 0, mre: 0, mwe: 0, ill: 0, rg: 0};
      stall = 1'b0; wr = 1'b0; ld = 1'b0;
      a = mread(rs1);
      case (op)
        3'b000: ;
        3'b001, 3'b100: begin
          if (rd < NREG && rs1 < NREG && (op == 3'b100 || rs2 < NREG)) begin
            opnd = (op == 3'b001) ? mread(rs2) : {{21{ins[10]}}, ins[10:0]};
            b.result = alu_ref(fn, a, opnd);
            b.rwe = 1'b1; b.rg = rd; wr = 1'b1;
            stall = mbusy(rs1) || mbusy(rd) || (op == 3'b001 && mbusy(rs2));
          end else b.ill = 1'b1;
        end
        3'b010, 3'b011: begin
          if (rd < NREG && rs1 < NREG) begin
            ea = a + {{18{ins[13]}}, ins[13:0]};
            b.result = ea; b.addr = ea;
            stall = mbusy(rs1) || mbusy(rd);
            if (op == 3'b010) begin b.mre = 1'b1; b.rg = rd; ld = 1'b1; end
            else begin b.mwe = 1'b1; b.sdata = mread(rd); end
          end else b.ill = 1'b1;
        end
        default: b.ill = 1'b1;
      endcase
      exp_ready = !stall && (!m_out_valid || out_ready);
      check("in_ready", in_ready, exp_ready);
      acc = in_valid && exp_ready;
      if (acc) exp_q.push_back(b);
      if (wb_en && wb_reg < NREG && wb_reg != 0) begin
        m_regs[wb_reg] = wb_data;
        m_pending[wb_reg] = 1'b0;
      end
      if (acc && wr && rd != 0) m_regs[rd] = b.result;
      if (acc && ld && rd != 0) m_pending[rd] = 1'b1;
      m_out_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_out_valid);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    bundle_t e;
    #1;
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) check("out_valid_spurious", out_valid, 1'b0);
      else begin
        e = exp_q[0];
        check("result", result, e.result);
        check("mem_address", mem_address, e.addr);
        check("store_data", store_data, e.sdata);
        check("reg_write_enable", reg_write_enable, e.rwe);
        check("mem_read_enable", mem_read_enable, e.mre);
        check("mem_write_enable", mem_write_enable, e.mwe);
        check("illegal", illegal, e.ill);
        check("register", register, e.rg);
        if (out_ready) begin
          last_result = result;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- random background drivers ----------------
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin : wb_driver
    int pq[$];
    int r;
    forever begin
      @(posedge clk); #1;
      if (rand_wb) begin
        wb_en = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          pq.delete();
          for (int i = 1; i < NREG; i++) if (m_pending[i]) pq.push_back(i);
          if (pq.size() > 0 && $urandom_range(0, 3) != 0) r = pq[$urandom_range(0, pq.size() - 1)];
          else r = $urandom_range(0, NREG - 1);
          wb_en = 1'b1; wb_reg = 5'(r); wb_data = $urandom();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_r(input logic [2:0] fn, input logic [4:0] rd, rs1, rs2);
    return {3'b001, rd, rs1, rs2, fn, 11'd0};
  endfunction
  function automatic logic [31:0] enc_i(input logic [2:0] fn, input logic [4:0] rd, rs1, input logic [10:0] imm);
    return {3'b100, rd, rs1, 5'd0, fn, imm};
  endfunction
  function automatic logic [31:0] enc_m(input logic [2:0] op, input logic [4:0] rd, rs1, input logic [13:0] imm);
    return {op, rd, rs1, 5'd0, imm};
  endfunction

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 19) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  op;
    int k;
    r = $urandom();
    k = $urandom_range(0, 19);
    if (k < 6) op = 3'b001;
    else if (k < 12) op = 3'b100;
    else if (k < 15) op = 3'b010;
    else if (k < 18) op = 3'b011;
    else if (k == 18) op = 3'b000;
    else op = 3'($urandom_range(5, 7));
    return {op, rreg(), rreg(), rreg(), r[13:0]};
  endfunction

  // Offer an instruction until accepted; called at posedge+1, returns at posedge+1.
  task automatic issue(input logic [31:0] ins, output int waits);
    logic done;
    waits = 0; done = 1'b0;
    in_valid = 1'b1; instruction = ins;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        waits++;
        if (waits > BUDGET) begin
          check("issue_timeout", waits, 0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_pulse(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_enables"}, {reg_write_enable, mem_read_enable, mem_write_enable}, 3'b000);
    check({tag, "_illegal"}, illegal, 1'b0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_mem_address"}, mem_address, 32'd0);
    check({tag, "_store_data"}, store_data, 32'd0);
    check({tag, "_register"}, register, 5'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w, w2;
    reset = 1'b1; in_valid = 1'b0; instruction = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0; last_result = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back dependent ALU ops.
    issue(enc_i(3'd0, 5'd1, 5'd0, 11'd5), w);
    check("addi_waits", w, 0);
    issue(enc_r(3'd0, 5'd2, 5'd1, 5'd1), w);
    check("add_no_bubble", w, 0);
    drain();
    check("add_r2_result", last_result, 32'd10);

    // Load then dependent add stalls until writeback.
    @(posedge clk); #1;
    issue(enc_m(3'b010, 5'd3, 5'd0, 14'd8), w);
    check("lw_mem_read_enable", mem_read_enable, 1'b1);
    check("lw_mem_address", mem_address, 32'd8);
    fork
      issue(enc_r(3'd0, 5'd4, 5'd3, 5'd1), w);
      begin repeat (3) @(posedge clk); #1; wb_pulse(5'd3, 32'd7); end
    join
    check("load_use_stall_cycles", w, 3);
    drain();
    check("add_r4_result", last_result, 32'd12);

    // Writeback bypass on the same cycle as the read.
    @(posedge clk); #1;
    issue(enc_m(3'b010, 5'd3, 5'd0, 14'd0), w);
    fork
      issue(enc_r(3'd0, 5'd5, 5'd3, 5'd0), w);
      wb_pulse(5'd3, 32'd9);
    join
    check("bypass_waits", w, 0);
    drain();
    check("bypass_result", last_result, 32'd9);

    // Downstream backpressure for 3 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(enc_i(3'd0, 5'd6, 5'd0, 11'd100), w);
    fork
      issue(enc_i(3'd0, 5'd7, 5'd6, 11'd1), w2);
      begin repeat (3) @(posedge clk); #1; out_ready = 1'b1; end
    join
    check("backpressure_waits", w2, 3);
    drain();
    check("after_backpressure_result", last_result, 32'd101);

    // Illegal encodings and register-range boundaries.
    @(posedge clk); #1;
    issue(32'hE000_0000, w);
    issue(enc_i(3'd0, 5'd31, 5'd1, 11'd3), w);
    issue(enc_r(3'd0, 5'd8, 5'd1, 5'd16), w);
    issue(enc_i(3'd0, 5'd15, 5'd1, 11'h7FF), w);
    issue(enc_r(3'd0, 5'd8, 5'd15, 5'd0), w);
    drain();
    check("boundary_r15_result", last_result, 32'd4);
    @(posedge clk); #1;
    issue(enc_m(3'b011, 5'd4, 5'd2, 14'h3FFC), w);
    check("sw_store_data", store_data, 32'd12);
    check("sw_mem_address", mem_address, 32'd6);

    // Reset during a load-use stall with a held bundle.
    issue(enc_m(3'b010, 5'd3, 5'd0, 14'd0), w);
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = enc_r(3'd0, 5'd9, 5'd3, 5'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    issue(enc_r(3'd0, 5'd9, 5'd3, 5'd0), w);
    check("post_reset_waits", w, 0);
    drain();
    check("post_reset_r3_zero", last_result, 32'd0);

    // Randomized traffic with random writebacks and backpressure.
    @(posedge clk); #1;
    rand_ready = 1'b1; rand_wb = 1'b1;
    for (int n = 0; n < 400; n++) issue(rand_instr(), w);
    rand_ready = 1'b0; rand_wb = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1; wb_en = 1'b0;
    drain();
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
